pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports are clk and rst.
REQ-002 The ports SHALL be, in order: clk in 1 rising-edge clock; rst in 1 async active-high reset.
REQ-003 ID stage inputs: IfIdRs in 5 ID source register; IfIdRt in 5 ID target register; IfId_useRt in 1 ID instruction reads Rt; IfId_isBranchType in 1 BEQ/BNE/JR/JALR in ID; Branch_taken in 1 ID branch/jump resolved taken.
REQ-004 EX stage inputs: IdExRd in 5 EX destination register; IdEx_RegWrite in 1; IdEx_MemRead in 1 (load in EX).
REQ-005 Cache inputs: ICache_stall in 1; DCache_stall in 1.
REQ-006 Outputs, 1 bit each: PC_write, IfId_write, IfId_flush, IdEx_write, IdEx_flush (insert bubble), ExMem_write, MemWb_write.
REQ-007 Statistics outputs: StallCount out 16 (bubbles inserted, registered); FreezeCount out 16 (cache-freeze cycles, registered).

Function
REQ-008 Match function: m(r) = (r != 0) && (r == IfIdRs || (IfId_useRt && r == IfIdRt)).
REQ-009 Load-use hazard: hz_lu = IdEx_MemRead && m(IdExRd) && !IfId_isBranchType.
REQ-010 Branch-after-ALU hazard: hz_b1 = IfId_isBranchType && IdEx_RegWrite && !IdEx_MemRead && m(IdExRd).
REQ-011 Branch-after-load hazard: hz_b2 = IfId_isBranchType && IdEx_MemRead && m(IdExRd).
REQ-012 FSM states SHALL be RUN and HOLD, plus a 1-bit remaining-bubble register bub.
REQ-013 Freeze condition: frz = ICache_stall || DCache_stall. The freeze has the highest priority.
REQ-014 When frz = 1: all seven write/flush outputs SHALL be 0, state and bub SHALL hold, FreezeCount SHALL increment, and StallCount SHALL hold.
REQ-015 Bubble cycle: PC_write = 0, IfId_write = 0, IdEx_flush = 1, IdEx_write = 1, ExMem_write = 1, MemWb_write = 1, IfId_flush = 0. StallCount SHALL increment.
REQ-016 In RUN with !frz and hz_lu or hz_b1: issue one bubble cycle and remain in RUN. The next cycle is re-evaluated normally.
REQ-017 In RUN with !frz and hz_b2: issue a bubble cycle, move to HOLD, and set bub = 1.
REQ-018 In HOLD with !frz: issue a bubble cycle unconditionally, clear bub, and return to RUN.
REQ-019 Normal cycle (RUN, !frz, no hazard): all *_write = 1, IdEx_flush = 0, and IfId_flush = Branch_taken.
REQ-020 Branch_taken SHALL be ignored in bubble and freeze cycles; IfId_flush SHALL never be 1 in the same cycle as IdEx_flush.
REQ-021 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-022 Outputs PC_write through MemWb_write SHALL be combinational from state, bub and inputs, with zero-cycle latency.

Reset
REQ-023 While rst = 1: state = RUN, bub = 0, StallCount = 0, FreezeCount = 0, and all seven control outputs SHALL be 0.
REQ-024 Reset asserted in HOLD SHALL abort the pending bubble. The first cycle after release SHALL be evaluated from RUN.

Structure
REQ-025 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, HOLD), the counter width constant (16) and the register index width (5).
REQ-026 Combinational sub-module hazard_detect SHALL compute hz_lu, hz_b1 and hz_b2. pipe_stall_ctrl SHALL own the FSM, the output decode and the counters.

Verification
REQ-027 Load-use: lw $3 in EX (IdExRd = 3, IdEx_MemRead = 1) with add using Rs = 3 in ID -> one cycle PC_write = 0, IdEx_flush = 1, StallCount = 1; the next cycle is normal.
REQ-028 Branch after load: IdExRd = 5 load, beq Rs = 5 in ID -> two consecutive bubble cycles, state RUN->HOLD->RUN, StallCount = 2.
REQ-029 $0 and Rt filtering: IdExRd = 0 with Rs = 0, then IdExRd = 7 with IfIdRt = 7 and IfId_useRt = 0 -> no bubble in either case.
REQ-030 Freeze in HOLD: DCache_stall = 1 for 3 cycles during HOLD -> all outputs 0 for those 3 cycles, FreezeCount = 3, then exactly one remaining bubble.
REQ-031 Taken branch during freeze, then normal: Branch_taken = 1 with ICache_stall = 1 -> IfId_flush = 0; Branch_taken = 1 in a normal cycle -> IfId_flush = 1.
REQ-032 Saturation and reset: force 65 540 bubbles -> StallCount = 16'hFFFF; assert rst mid-HOLD -> state RUN, counters 0, no residual bubble.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds the FSM state encoding, counter width and register index width.
// Also provides the saturating increment used by both statistics counters.
package pipe_ctrl_pkg;
  localparam int CNT_W = 16;
  localparam int REG_W = 5;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// Data-hazard detection between the ID-stage consumer and the EX-stage producer.
// Purely combinational, zero latency.
// Has no flow control of its own; the controller decides how hazards stall the pipe.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             if_id_use_rt_i,
  input  logic             if_id_is_branch_i,
  input  logic [REG_W-1:0] id_ex_rd_i,
  input  logic             id_ex_reg_write_i,
  input  logic             id_ex_mem_read_i,
  output logic             hz_lu_o,
  output logic             hz_b1_o,
  output logic             hz_b2_o
);

  logic ex_match;

  // EX destination feeds an ID source; $0 never creates a dependency and Rt
  // only counts when the ID instruction actually reads it.
  assign ex_match = (id_ex_rd_i != '0) &&
                    ((id_ex_rd_i == if_id_rs_i) ||
                     (if_id_use_rt_i && (id_ex_rd_i == if_id_rt_i)));

  // Load-use for ordinary instructions; branches are handled by the b2 case.
  assign hz_lu_o = id_ex_mem_read_i && ex_match && !if_id_is_branch_i;

  // Branches compare in ID, so an ALU result still in EX needs one bubble.
  assign hz_b1_o = if_id_is_branch_i && id_ex_reg_write_i && !id_ex_mem_read_i && ex_match;

  // Branch behind a load needs the loaded value, which is two cycles away.
  assign hz_b2_o = if_id_is_branch_i && id_ex_mem_read_i && ex_match;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller with cache freeze and bubble statistics.
// Control outputs are combinational (zero latency); counters are registered.
// Cache stall freezes everything; hazards insert one or two bubbles in ID/EX.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IfIdRs,
  input  logic [REG_W-1:0] IfIdRt,
  input  logic             IfId_useRt,
  input  logic             IfId_isBranchType,
  input  logic             Branch_taken,
  input  logic [REG_W-1:0] IdExRd,
  input  logic             IdEx_RegWrite,
  input  logic             IdEx_MemRead,
  input  logic             ICache_stall,
  input  logic             DCache_stall,
  output logic             PC_write,
  output logic             IfId_write,
  output logic             IfId_flush,
  output logic             IdEx_write,
  output logic             IdEx_flush,
  output logic             ExMem_write,
  output logic             MemWb_write,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FreezeCount
);

  state_t           state_q, state_d;
  logic             bub_q, bub_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] frz_cnt_q, frz_cnt_d;

  logic hz_lu, hz_b1, hz_b2;
  logic frz;
  logic bubble;

  hazard_detect u_hazard_detect (
    .if_id_rs_i        (IfIdRs),
    .if_id_rt_i        (IfIdRt),
    .if_id_use_rt_i    (IfId_useRt),
    .if_id_is_branch_i (IfId_isBranchType),
    .id_ex_rd_i        (IdExRd),
    .id_ex_reg_write_i (IdEx_RegWrite),
    .id_ex_mem_read_i  (IdEx_MemRead),
    .hz_lu_o           (hz_lu),
    .hz_b1_o           (hz_b1),
    .hz_b2_o           (hz_b2)
  );

  assign frz    = ICache_stall || DCache_stall;
  // A pending second bubble from HOLD wins over any new hazard evaluation.
  assign bubble = !frz && (((state_q == HOLD) && bub_q) || hz_lu || hz_b1 || hz_b2);

  // Output decode: reset and freeze force everything low, bubbles stall the front end.
  always_comb begin
    PC_write    = 1'b0;
    IfId_write  = 1'b0;
    IfId_flush  = 1'b0;
    IdEx_write  = 1'b0;
    IdEx_flush  = 1'b0;
    ExMem_write = 1'b0;
    MemWb_write = 1'b0;
    if (!rst && !frz) begin
      IdEx_write  = 1'b1;
      ExMem_write = 1'b1;
      MemWb_write = 1'b1;
      if (bubble) begin
        IdEx_flush = 1'b1;
      end else begin
        PC_write   = 1'b1;
        IfId_write = 1'b1;
        IfId_flush = Branch_taken;
      end
    end
  end

  // Next-state: freeze holds state, a branch-after-load arms one extra bubble.
  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    stall_cnt_d = bubble ? sat_inc(stall_cnt_q) : stall_cnt_q;
    frz_cnt_d   = frz ? sat_inc(frz_cnt_q) : frz_cnt_q;
    if (!frz) begin
      case (state_q)
        RUN: begin
          if (hz_b2) begin
            state_d = HOLD;
            bub_d   = 1'b1;
          end
        end
        HOLD: begin
          state_d = RUN;
          bub_d   = 1'b0;
        end
        default: begin
          state_d = RUN;
          bub_d   = 1'b0;
        end
      endcase
    end
  end

  // FSM and statistics registers; reset drops any pending bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      bub_q       <= 1'b0;
      stall_cnt_q <= '0;
      frz_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bub_q       <= bub_d;
      stall_cnt_q <= stall_cnt_d;
      frz_cnt_q   <= frz_cnt_d;
    end
  end

  assign StallCount  = stall_cnt_q;
  assign FreezeCount = frz_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed table, corner sequences,
// randomized run against a pending-bubble reference model, counter saturation.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IfIdRs, IfIdRt, IdExRd;
  logic        IfId_useRt, IfId_isBranchType, Branch_taken;
  logic        IdEx_RegWrite, IdEx_MemRead, ICache_stall, DCache_stall;
  logic        PC_write, IfId_write, IfId_flush, IdEx_write, IdEx_flush, ExMem_write, MemWb_write;
  logic [15:0] StallCount, FreezeCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfId_useRt(IfId_useRt),
    .IfId_isBranchType(IfId_isBranchType), .Branch_taken(Branch_taken),
    .IdExRd(IdExRd), .IdEx_RegWrite(IdEx_RegWrite), .IdEx_MemRead(IdEx_MemRead),
    .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
    .PC_write(PC_write), .IfId_write(IfId_write), .IfId_flush(IfId_flush),
    .IdEx_write(IdEx_write), .IdEx_flush(IdEx_flush),
    .ExMem_write(ExMem_write), .MemWb_write(MemWb_write),
    .StallCount(StallCount), .FreezeCount(FreezeCount)
  );

  // {PC_write, IfId_write, IfId_flush, IdEx_write, IdEx_flush, ExMem_write, MemWb_write}
  wire [6:0] outs = {PC_write, IfId_write, IfId_flush, IdEx_write, IdEx_flush, ExMem_write, MemWb_write};
  localparam logic [6:0] NORM    = 7'b1101011;
  localparam logic [6:0] NORM_BR = 7'b1111011;
  localparam logic [6:0] BUB     = 7'b0001111;
  localparam logic [6:0] ZERO    = 7'b0000000;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urt, br, tk;
    logic [4:0] rd;
    logic       rw, mr, ic, dc;
    logic [6:0] exp_out;
    int         exp_sc, exp_fc;
  } vec_t;

  function automatic vec_t mk(input int rs, input int rt, input bit urt, input bit br, input bit tk,
                              input int rd, input bit rw, input bit mr, input bit ic, input bit dc,
                              input logic [6:0] eo, input int sc, input int fc);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urt = urt; v.br = br; v.tk = tk;
    v.rd = 5'(rd); v.rw = rw; v.mr = mr; v.ic = ic; v.dc = dc;
    v.exp_out = eo; v.exp_sc = sc; v.exp_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs on the falling edge.
  task automatic drive(input vec_t v, input bit r);
    @(negedge clk);
    rst = r;
    IfIdRs = v.rs; IfIdRt = v.rt; IfId_useRt = v.urt; IfId_isBranchType = v.br;
    Branch_taken = v.tk; IdExRd = v.rd; IdEx_RegWrite = v.rw; IdEx_MemRead = v.mr;
    ICache_stall = v.ic; DCache_stall = v.dc;
  endtask

  // Apply a vector, check outputs before the edge and counters after it.
  task automatic run_vec(input string name, input vec_t v);
    drive(v, 1'b0);
    #1;
    chk({name, ".outs"}, int'(outs), int'(v.exp_out));
    @(posedge clk);
    #1;
    chk({name, ".stall"}, int'(StallCount), v.exp_sc);
    chk({name, ".freeze"}, int'(FreezeCount), v.exp_fc);
  endtask

  task automatic do_reset();
    vec_t z;
    z = mk(0,0,0,0,0, 0,0,0,0,0, ZERO,0,0);
    drive(z, 1'b1);
    @(posedge clk);
    drive(z, 1'b1);
    @(posedge clk);
  endtask

  // Reference model: pending bubble count plus plain integer counters.
  int m_pend, m_sc, m_fc;

  function automatic bit dep(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt, input bit urt);
    return (r != 0) && (r == rs || (urt && r == rt));
  endfunction

  vec_t tbl[$];
  vec_t z0;

  initial begin
    rst = 1'b1;
    IfIdRs = 0; IfIdRt = 0; IfId_useRt = 0; IfId_isBranchType = 0; Branch_taken = 0;
    IdExRd = 0; IdEx_RegWrite = 0; IdEx_MemRead = 0; ICache_stall = 0; DCache_stall = 0;
    z0 = mk(0,0,0,0,0, 0,0,0,0,0, NORM,0,0);

    // Reset state
    @(posedge clk); #1;
    chk("rst.outs", int'(outs), int'(ZERO));
    chk("rst.stall", int'(StallCount), 0);
    chk("rst.freeze", int'(FreezeCount), 0);

    //          rs rt urt br tk  rd rw mr ic dc   out     sc fc
    tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0, NORM,   0,0));
    tbl.push_back(mk(3, 0,0,0,0,  3,1,1,0,0, BUB,    1,0));  // lw $3 ; add rs=$3
    tbl.push_back(mk(4, 3,0,0,0,  3,1,1,0,0, NORM,   1,0));  // Rt not read
    tbl.push_back(mk(4, 3,1,0,0,  3,1,1,0,0, BUB,    2,0));  // Rt read
    tbl.push_back(mk(0, 0,1,0,0,  0,1,1,0,0, NORM,   2,0));  // $0 never hazards
    tbl.push_back(mk(1, 7,0,0,0,  7,1,1,0,0, NORM,   2,0));
    tbl.push_back(mk(9, 0,0,1,0,  9,1,0,0,0, BUB,    3,0));  // branch after ALU
    tbl.push_back(mk(9, 0,0,1,0,  9,0,0,0,0, NORM,   3,0));  // no write in EX
    tbl.push_back(mk(2, 0,0,1,1,  6,1,0,0,0, NORM_BR,3,0));  // taken, normal
    tbl.push_back(mk(0, 0,0,1,1,  0,0,0,1,0, ZERO,   3,1));  // taken during I$ freeze
    tbl.push_back(mk(3, 0,0,0,0,  3,1,1,0,1, ZERO,   3,2));  // freeze beats hazard
    tbl.push_back(mk(5, 0,0,1,0,  5,1,1,0,0, BUB,    4,2));  // branch after load -> HOLD
    tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0, BUB,    5,2));  // HOLD bubble
    tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0, NORM,   5,2));
    tbl.push_back(mk(8, 0,0,1,1,  8,1,0,0,0, BUB,    6,2));  // taken ignored in bubble
    tbl.push_back(mk(0, 5,1,1,0,  5,1,1,0,0, BUB,    7,2));  // b2 via Rt -> HOLD
    tbl.push_back(mk(0, 0,0,0,1,  0,0,0,0,1, ZERO,   7,3));  // D$ freeze in HOLD x3
    tbl.push_back(mk(0, 0,0,0,1,  0,0,0,0,1, ZERO,   7,4));
    tbl.push_back(mk(0, 0,0,0,1,  0,0,0,0,1, ZERO,   7,5));
    tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0, BUB,    8,5));  // remaining bubble
    tbl.push_back(mk(0, 0,0,0,1,  0,0,0,0,0, NORM_BR,8,5));

    drive(z0, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Reset asserted mid-HOLD aborts the pending bubble
    run_vec("hold_entry", mk(5,0,0,1,0, 5,1,1,0,0, BUB, 9,5));
    drive(z0, 1'b1);
    #1;
    chk("rst_hold.outs", int'(outs), int'(ZERO));
    chk("rst_hold.stall_async", int'(StallCount), 0);
    chk("rst_hold.freeze_async", int'(FreezeCount), 0);
    @(posedge clk);
    run_vec("after_rst", mk(0,0,0,0,0, 0,0,0,0,0, NORM, 0,0));

    // Randomized run against the reference model
    do_reset();
    m_pend = 0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      bit r, f, lu, b1, b2, bub;
      logic [6:0] eo;
      r = ($urandom_range(0, 63) == 0);
      v = mk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,2) == 0,
             $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,9) == 0, $urandom_range(0,9) == 0, ZERO, 0, 0);
      f  = v.ic || v.dc;
      lu = v.mr && dep(v.rd, v.rs, v.rt, v.urt) && !v.br;
      b1 = v.br && v.rw && !v.mr && dep(v.rd, v.rs, v.rt, v.urt);
      b2 = v.br && v.mr && dep(v.rd, v.rs, v.rt, v.urt);
      bub = 1'b0;
      if (r) begin
        eo = ZERO; m_pend = 0; m_sc = 0; m_fc = 0;
      end else if (f) begin
        eo = ZERO; m_fc = (m_fc < 65535) ? m_fc + 1 : 65535;
      end else if (m_pend > 0) begin
        bub = 1'b1; m_pend = m_pend - 1;
      end else if (lu || b1) begin
        bub = 1'b1;
      end else if (b2) begin
        bub = 1'b1; m_pend = 1;
      end else begin
        eo = v.tk ? NORM_BR : NORM;
      end
      if (bub) begin
        eo = BUB; m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
      end
      drive(v, r);
      #1;
      chk("rand.outs", int'(outs), int'(eo));
      @(posedge clk);
      #1;
      chk("rand.stall", int'(StallCount), m_sc);
      chk("rand.freeze", int'(FreezeCount), m_fc);
    end

    // Stall counter saturation: 65540 back-to-back load-use bubbles
    do_reset();
    begin
      vec_t lu_v;
      lu_v = mk(3,0,0,0,0, 3,1,1,0,0, BUB,0,0);
      for (int n = 1; n <= 65540; n++) begin
        drive(lu_v, 1'b0);
        @(posedge clk);
        if (n == 65534) begin
          #1;
          chk("sat.pre", int'(StallCount), 65534);
        end
      end
      #1;
      chk("sat.stall", int'(StallCount), 65535);
      chk("sat.freeze", int'(FreezeCount), 0);
      drive(lu_v, 1'b0);
      #1;
      chk("sat.outs", int'(outs), int'(BUB));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
